// File: rtl/fibo_stream_gen.sv
// Fibonacci-style term generator: F(0)=seed0, F(1)=seed1, F(k)=F(k-1)+F(k-2)
// up to F(order), optionally presenting every term on a valid/ready stream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no sequence; waiting for start
// RUN   | generating terms, busy=1
// DONE  | finished normally; done/result (and overflow if WRAP) held
// OVF   | stopped before presenting an overflowed term; result=all-ones
module fibo_stream_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int ORDER_WIDTH = 16,
  parameter int WRAP        = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DATA_WIDTH-1:0]  seed0,
  input  logic [DATA_WIDTH-1:0]  seed1,
  input  logic [ORDER_WIDTH-1:0] order,
  input  logic                   stream_en,
  input  logic                   term_ready,
  output logic                   term_valid,
  output logic [DATA_WIDTH-1:0]  term,
  output logic [ORDER_WIDTH-1:0] term_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [DATA_WIDTH-1:0]  result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] OVF  = 2'd3;

  logic [1:0]             state;
  logic [DATA_WIDTH-1:0]  cur;
  logic [DATA_WIDTH-1:0]  nxt;
  logic                   nxt_flag;   // nxt is (or follows) a term that overflowed
  logic [ORDER_WIDTH-1:0] idx;
  logic [ORDER_WIDTH-1:0] order_q;
  logic                   stream_q;
  logic [DATA_WIDTH:0]    sum;
  logic                   advance;
  logic                   last;

  assign sum        = {1'b0, cur} + {1'b0, nxt};
  assign busy       = (state == RUN);
  assign term_valid = busy && stream_q;
  assign term       = cur;
  assign term_idx   = idx;
  assign last       = (idx == order_q);
  // Abort wins over any advance in the same cycle.
  assign advance    = busy && !abort && (!stream_q || term_ready);

  // Sequencer: start/abort handling and term advance with overflow tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      nxt      <= '0;
      nxt_flag <= 1'b0;
      idx      <= '0;
      order_q  <= '0;
      stream_q <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE, DONE, OVF: begin
          if (start) begin
            state    <= RUN;
            cur      <= seed0;
            nxt      <= seed1;
            nxt_flag <= 1'b0;
            idx      <= '0;
            order_q  <= order;
            stream_q <= stream_en;
            done     <= 1'b0;
            overflow <= 1'b0;
            result   <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (advance) begin
            if (last) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= cur;
            end else if (nxt_flag && (WRAP == 0)) begin
              // The next term is not representable: stop before showing it.
              state    <= OVF;
              overflow <= 1'b1;
              result   <= '1;
            end else begin
              cur      <= nxt;
              nxt      <= sum[DATA_WIDTH-1:0];
              nxt_flag <= sum[DATA_WIDTH] | nxt_flag;
              idx      <= idx + 1'b1;
              if (nxt_flag) begin
                overflow <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_stream_gen.sv
// Directed bench for fibo_stream_gen: a 64-bit instance plus 8-bit abort-on-
// overflow and 8-bit wrapping instances, all on one clock and reset.
module tb_fibo_stream_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, start8 = 1'b0, start8w = 1'b0;
  logic        abort = 1'b0;
  logic        stream_en = 1'b0;
  logic        term_ready = 1'b0;
  logic [15:0] order = '0;
  logic [63:0] seed0 = '0, seed1 = '0;
  logic [7:0]  s8_0 = '0, s8_1 = '0;

  logic        tv, bsy, dn, ov;
  logic [63:0] tm, res;
  logic [15:0] ti;
  logic        tv8, bsy8, dn8, ov8;
  logic [7:0]  tm8, res8;
  logic [15:0] ti8;
  logic        tv8w, bsy8w, dn8w, ov8w;
  logic [7:0]  tm8w, res8w;
  logic [15:0] ti8w;

  int checks = 0;
  int errors = 0;

  int fib10[11] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
  int fib8w[15] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
  int s21[6]    = '{2, 1, 3, 4, 7, 11};

  always #5 clk = ~clk;

  fibo_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .seed0(seed0), .seed1(seed1), .order(order), .stream_en(stream_en),
    .term_ready(term_ready), .term_valid(tv), .term(tm), .term_idx(ti),
    .busy(bsy), .done(dn), .overflow(ov), .result(res)
  );

  fibo_stream_gen #(.DATA_WIDTH(8), .ORDER_WIDTH(16), .WRAP(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort),
    .seed0(s8_0), .seed1(s8_1), .order(order), .stream_en(stream_en),
    .term_ready(term_ready), .term_valid(tv8), .term(tm8), .term_idx(ti8),
    .busy(bsy8), .done(dn8), .overflow(ov8), .result(res8)
  );

  fibo_stream_gen #(.DATA_WIDTH(8), .ORDER_WIDTH(16), .WRAP(1)) dut8w (
    .clk(clk), .rst_n(rst_n), .start(start8w), .abort(abort),
    .seed0(s8_0), .seed1(s8_1), .order(order), .stream_en(stream_en),
    .term_ready(term_ready), .term_valid(tv8w), .term(tm8w), .term_idx(ti8w),
    .busy(bsy8w), .done(dn8w), .overflow(ov8w), .result(res8w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset values (asynchronous) ----------------
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", tv, 0);    chk("rst_busy", bsy, 0);
    chk("rst_done", dn, 0);     chk("rst_ovf", ov, 0);
    chk("rst_term", tm, 0);     chk("rst_idx", ti, 0);
    chk("rst_result", res, 0);  chk("rst8_busy", bsy8, 0);
    chk("rst8w_busy", bsy8w, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---------------- seeds 0,1 order 10, streamed ----------------
    seed0 = 0; seed1 = 1; order = 10; stream_en = 1; term_ready = 1;
    start = 1;
    tick();
    start = 0;
    chk("t1_busy", bsy, 1);
    for (int k = 0; k <= 10; k++) begin
      chk($sformatf("t1_valid%0d", k), tv, 1);
      chk($sformatf("t1_term%0d", k), tm, fib10[k]);
      chk($sformatf("t1_idx%0d", k), ti, k);
      chk($sformatf("t1_done_lo%0d", k), dn, 0);
      tick();
    end
    chk("t1_done", dn, 1);      chk("t1_result", res, 55);
    chk("t1_valid_off", tv, 0); chk("t1_busy_off", bsy, 0);
    chk("t1_ovf", ov, 0);
    // abort outside RUN is ignored
    abort = 1;
    tick();
    abort = 0;
    chk("abort_done_hold", dn, 1);
    chk("abort_res_hold", res, 55);

    // ---------------- seeds 2,1 order 5, backpressure at idx 2 ----------------
    seed0 = 2; seed1 = 1; order = 5;
    start = 1;
    tick();
    start = 0;
    chk("t2_done_clr", dn, 0);
    chk("t2_res_clr", res, 0);
    chk("t2_term0", tm, s21[0]);
    tick();
    chk("t2_term1", tm, s21[1]);
    tick();
    term_ready = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_hold_valid%0d", i), tv, 1);
      chk($sformatf("t2_hold_term%0d", i), tm, 3);
      chk($sformatf("t2_hold_idx%0d", i), ti, 2);
      if (i == 2) term_ready = 1;
      tick();
    end
    for (int k = 3; k <= 5; k++) begin
      chk($sformatf("t2_term%0d", k), tm, s21[k]);
      chk($sformatf("t2_idx%0d", k), ti, k);
      tick();
    end
    chk("t2_done", dn, 1);
    chk("t2_result", res, 11);

    // ---------------- order 0, start during RUN ignored ----------------
    seed0 = 9; seed1 = 4; order = 0;
    start = 1;
    tick();
    seed0 = 5; order = 3;   // start still high while busy
    chk("t3_valid", tv, 1);
    chk("t3_term", tm, 9);
    chk("t3_idx", ti, 0);
    tick();
    start = 0;
    chk("t3_done", dn, 1);
    chk("t3_result", res, 9);
    chk("t3_busy", bsy, 0);

    // ---------------- stream_en=0: one term per cycle ----------------
    seed0 = 3; seed1 = 4; order = 6; stream_en = 0; term_ready = 0;
    start = 1;
    tick();
    start = 0;
    chk("t4_busy", bsy, 1);
    chk("t4_no_valid", tv, 0);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk($sformatf("t4_idx_c%0d", c), ti, c - 1);
    end
    tick();
    chk("t4_done", dn, 1);
    chk("t4_result", res, 47);

    // ---------------- start mid-run ignored, then abort+start at idx 4 ----------------
    seed0 = 0; seed1 = 1; order = 10; stream_en = 1; term_ready = 1;
    start = 1;
    tick();
    start = 0;
    tick(); tick();
    seed0 = 7; seed1 = 7; start = 1;
    tick();
    start = 0;
    chk("t5_ignored_idx", ti, 3);
    chk("t5_ignored_term", tm, 2);
    tick();
    chk("t5_idx4", ti, 4);
    chk("t5_term4", tm, 3);
    abort = 1; start = 1;
    tick();
    abort = 0; start = 0;
    chk("t5_busy", bsy, 0);
    chk("t5_valid", tv, 0);
    chk("t5_done", dn, 0);
    chk("t5_result", res, 0);
    tick();
    chk("t5_still_idle", bsy, 0);

    // ---------------- reset mid-run is immediate ----------------
    seed0 = 0; seed1 = 1; order = 10;
    start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    chk("t6_pre_idx", ti, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", tv, 0);  chk("t6_busy", bsy, 0);
    chk("t6_term", tm, 0);   chk("t6_idx", ti, 0);
    chk("t6_done", dn, 0);   chk("t6_ovf", ov, 0);
    chk("t6_result", res, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_resume", bsy, 0);

    // ---------------- 8-bit, WRAP=0, order 20 ----------------
    s8_0 = 0; s8_1 = 1; order = 20; stream_en = 1; term_ready = 1;
    start8 = 1;
    tick();
    start8 = 0;
    for (int k = 0; k <= 13; k++) begin
      chk($sformatf("t7_valid%0d", k), tv8, 1);
      chk($sformatf("t7_term%0d", k), tm8, fib8w[k]);
      chk($sformatf("t7_idx%0d", k), ti8, k);
      tick();
    end
    chk("t7_valid_off", tv8, 0);
    chk("t7_ovf", ov8, 1);
    chk("t7_done", dn8, 0);
    chk("t7_result", res8, 8'hFF);
    chk("t7_busy", bsy8, 0);
    tick();
    chk("t7_ovf_hold", ov8, 1);
    chk("t7_valid_hold", tv8, 0);

    // ---------------- 8-bit, WRAP=1, order 14 ----------------
    order = 14;
    start8w = 1;
    tick();
    start8w = 0;
    for (int k = 0; k <= 14; k++) begin
      chk($sformatf("t8_term%0d", k), tm8w, fib8w[k]);
      chk($sformatf("t8_idx%0d", k), ti8w, k);
      chk($sformatf("t8_ovf%0d", k), ov8w, (k == 14) ? 1 : 0);
      tick();
    end
    chk("t8_done", dn8w, 1);
    chk("t8_ovf_final", ov8w, 1);
    chk("t8_result", res8w, 121);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
